// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit controller.
//   lsu_state_t           - controller FSM state encoding
//   BYTE_WIDTH            - width of one memory byte lane
//   DEFAULT_START_ADDRESS - lowest legal data address (default)
//   DEFAULT_END_ADDRESS   - highest legal data address (default)
//   LAST_BYTE_OFFSET      - offset of the last byte touched by a word access
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StSplit,
        StResp
    } lsu_state_t;

    localparam int unsigned BYTE_WIDTH            = 8;
    localparam logic [31:0] DEFAULT_START_ADDRESS = 32'h0001_0000;
    localparam logic [31:0] DEFAULT_END_ADDRESS   = 32'h0001_FFFF;
    localparam int unsigned LAST_BYTE_OFFSET      = 3;

endpackage

// File: rtl/lsu_range_check.sv
// ---------------------------------------------------------------------------
// lsu_range_check
// Combinational legality check of a data access against the address window.
//   addr_i   - first byte address of the access
//   byte_i   - 1 = single byte access, 0 = word access
//   legal_o  - 1 when every byte of the access lies inside the window
// The last byte address is formed in DATA_WIDTH+1 bits so a word access that
// wraps past the top of the address space lands above END_ADDRESS.
// ---------------------------------------------------------------------------
module lsu_range_check
    import lsu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] START_ADDRESS = DEFAULT_START_ADDRESS,
    parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = DEFAULT_END_ADDRESS
) (
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic                  byte_i,
    output logic                  legal_o
);

    localparam logic [DATA_WIDTH:0] LastOffset = (DATA_WIDTH + 1)'(LAST_BYTE_OFFSET);

    logic [DATA_WIDTH:0] last;

    always_comb begin
        last    = {1'b0, addr_i} + (byte_i ? '0 : LastOffset);
        legal_o = (addr_i >= START_ADDRESS) && (last <= {1'b0, END_ADDRESS});
    end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller between the execute stage and data_memory.
// Accepts one request at a time, performs aligned/byte accesses in a single
// memory cycle and splits misaligned words into four byte beats.
//   clk, rst       - clock and synchronous active-high reset
//   req_*          - request handshake and latched operands
//   resp_*         - one-cycle completion pulse with load data / range error
//   mem_*          - data_memory port (writes land on the clk negedge)
// ---------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           BYTE_WIDTH    = lsu_pkg::BYTE_WIDTH,
    parameter logic [DATA_WIDTH-1:0] START_ADDRESS = DEFAULT_START_ADDRESS,
    parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = DEFAULT_END_ADDRESS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic                  req_byte_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wd_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rd_o,
    output logic                  resp_err_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam int unsigned LaneW = $clog2(DATA_WIDTH);

    lsu_state_t            state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  err_q, err_d;

    logic                  req_legal;
    logic                  mem_we_raw;
    logic [LaneW-1:0]      lane_lsb;

    // The range decision is taken at the accepting edge, so it looks at the
    // request operands that are being latched in that same cycle.
    lsu_range_check #(
        .DATA_WIDTH    (DATA_WIDTH),
        .START_ADDRESS (START_ADDRESS),
        .END_ADDRESS   (END_ADDRESS)
    ) u_range_check (
        .addr_i  (req_addr_i),
        .byte_i  (req_byte_i),
        .legal_o (req_legal)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        we_d          = we_q;
        byte_d        = byte_q;
        addr_d        = addr_q;
        wd_d          = wd_q;
        rd_d          = rd_q;
        err_d         = err_q;
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_rd_o     = '0;
        resp_err_o    = 1'b0;
        mem_addr_o    = '0;
        mem_wd_o      = '0;
        mem_we_raw    = 1'b0;
        mem_byte_op_o = 1'b0;
        lane_lsb      = LaneW'(BYTE_WIDTH * 32'(k_q));

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d   = req_we_i;
                    byte_d = req_byte_i;
                    addr_d = req_addr_i;
                    wd_d   = req_wd_i;
                    rd_d   = '0;
                    err_d  = !req_legal;
                    k_d    = 2'd0;
                    if (!req_legal) begin
                        state_d = StResp;
                    end else if (req_byte_i || (req_addr_i[1:0] == 2'b00)) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StSplit;
                    end
                end
            end

            StAccess: begin
                mem_addr_o    = addr_q;
                mem_byte_op_o = byte_q;
                mem_we_raw    = we_q;
                mem_wd_o      = wd_q;
                if (!we_q) begin
                    rd_d = byte_q ? DATA_WIDTH'(mem_rd_i[BYTE_WIDTH-1:0]) : mem_rd_i;
                end
                state_d = StResp;
            end

            StSplit: begin
                mem_addr_o    = addr_q + DATA_WIDTH'(k_q);
                mem_byte_op_o = 1'b1;
                mem_we_raw    = we_q;
                mem_wd_o      = DATA_WIDTH'(wd_q[lane_lsb +: BYTE_WIDTH]);
                if (!we_q) begin
                    rd_d[lane_lsb +: BYTE_WIDTH] = mem_rd_i[BYTE_WIDTH-1:0];
                end
                if (k_q == 2'd3) begin
                    k_d     = 2'd0;
                    state_d = StResp;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end

            StResp: begin
                resp_valid_o = 1'b1;
                resp_rd_o    = rd_q;
                resp_err_o   = err_q;
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Suppress the negedge write in the reset cycle so an aborted split
        // store never lands an extra beat.
        mem_we_o = mem_we_raw & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl with a small byte-addressed memory model that
// writes on the clock negedge and reads combinationally (little endian).
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        resp_valid;
    logic [31:0] resp_rd;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_byte_op;
    logic [31:0] mem_rd;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;

    lsu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_byte_i    (req_byte),
        .req_addr_i    (req_addr),
        .req_wd_i      (req_wd),
        .resp_valid_o  (resp_valid),
        .resp_rd_o     (resp_rd),
        .resp_err_o    (resp_err),
        .mem_addr_o    (mem_addr),
        .mem_wd_o      (mem_wd),
        .mem_we_o      (mem_we),
        .mem_byte_op_o (mem_byte_op),
        .mem_rd_i      (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 256 bytes aliased on addr[7:0]. Reads always return the
    // full word at the address so byte loads see junk in the upper bits.
    logic [7:0] mem [256];
    logic [7:0] ma0, ma1, ma2, ma3;
    assign ma0 = mem_addr[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;
    assign mem_rd = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};

    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_byte_op) begin
                mem[ma0] = mem_wd[7:0];
            end else begin
                mem[ma0] = mem_wd[7:0];
                mem[ma1] = mem_wd[15:8];
                mem[ma2] = mem_wd[23:16];
                mem[ma3] = mem_wd[31:24];
            end
        end
    end

    always @(posedge clk) begin
        if (resp_valid) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents a request in IDLE and advances past the accepting edge.
    task automatic issue(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byt;
        req_addr  = addr;
        req_wd    = wd;
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wd    = 32'h5555_5555;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wd    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h04] = 8'h11;
        mem[8'h05] = 8'h22;
        mem[8'h06] = 8'h33;
        mem[8'h07] = 8'h44;
        mem[8'hFF] = 8'h5A;
        mem[8'h02] = 8'h77;
        mem[8'h03] = 8'h66;

        tick();
        tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rd", resp_rd, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_byte", {31'b0, mem_byte_op}, 32'd0);
        rst = 1'b0;
        tick();

        // Aligned LW 0x10004
        issue(1'b0, 1'b0, 32'h0001_0004, 32'h0);
        chk("lw_mem_addr", mem_addr, 32'h0001_0004);
        chk("lw_mem_byte", {31'b0, mem_byte_op}, 32'd0);
        chk("lw_mem_we", {31'b0, mem_we}, 32'd0);
        chk("lw_ready_busy", {31'b0, req_ready}, 32'd0);
        chk("lw_no_early_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("lw_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("lw_resp_rd", resp_rd, 32'h4433_2211);
        chk("lw_resp_err", {31'b0, resp_err}, 32'd0);
        chk("lw_mem_idle", mem_addr, 32'd0);
        tick();
        chk("lw_back_idle", {31'b0, req_ready}, 32'd1);
        chk("lw_pulse_done", {31'b0, resp_valid}, 32'd0);

        // SB 0x10001 then LBU 0x10001
        issue(1'b1, 1'b1, 32'h0001_0001, 32'hDEAD_BEEF);
        chk("sb_mem_we", {31'b0, mem_we}, 32'd1);
        chk("sb_mem_byte", {31'b0, mem_byte_op}, 32'd1);
        chk("sb_mem_addr", mem_addr, 32'h0001_0001);
        chk("sb_mem_wd_lo", {24'b0, mem_wd[7:0]}, 32'h0000_00EF);
        tick();
        chk("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("sb_resp_rd", resp_rd, 32'd0);
        chk("sb_mem_byte1", {24'b0, mem[8'h01]}, 32'h0000_00EF);
        chk("sb_mem_byte2", {24'b0, mem[8'h02]}, 32'h0000_0077);
        tick();
        issue(1'b0, 1'b1, 32'h0001_0001, 32'h0);
        tick();
        chk("lbu_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("lbu_resp_rd", resp_rd, 32'h0000_00EF);
        tick();

        // Misaligned SW 0x10002 then LW 0x10002
        issue(1'b1, 1'b0, 32'h0001_0002, 32'hA1B2_C3D4);
        chk("sws_b0_addr", mem_addr, 32'h0001_0002);
        chk("sws_b0_wd", mem_wd, 32'h0000_00D4);
        chk("sws_b0_we", {30'b0, mem_we, mem_byte_op}, 32'd3);
        tick();
        chk("sws_b1_addr", mem_addr, 32'h0001_0003);
        chk("sws_b1_wd", mem_wd, 32'h0000_00C3);
        tick();
        chk("sws_b2_addr", mem_addr, 32'h0001_0004);
        chk("sws_b2_wd", mem_wd, 32'h0000_00B2);
        tick();
        chk("sws_b3_addr", mem_addr, 32'h0001_0005);
        chk("sws_b3_wd", mem_wd, 32'h0000_00A1);
        chk("sws_b3_no_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("sws_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("sws_resp_err", {31'b0, resp_err}, 32'd0);
        chk("sws_resp_rd", resp_rd, 32'd0);
        chk("sws_mem_bytes", {mem[8'h05], mem[8'h04], mem[8'h03], mem[8'h02]}, 32'hA1B2_C3D4);
        tick();
        issue(1'b0, 1'b0, 32'h0001_0002, 32'h0);
        chk("swl_b0_we", {30'b0, mem_we, mem_byte_op}, 32'd1);
        tick();
        tick();
        tick();
        chk("swl_b3_addr", mem_addr, 32'h0001_0005);
        tick();
        chk("swl_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("swl_resp_rd", resp_rd, 32'hA1B2_C3D4);
        tick();

        // Range errors
        issue(1'b0, 1'b0, 32'h0000_FFFC, 32'h0);
        chk("err_low_valid", {31'b0, resp_valid}, 32'd1);
        chk("err_low_err", {31'b0, resp_err}, 32'd1);
        chk("err_low_rd", resp_rd, 32'd0);
        chk("err_low_we", {31'b0, mem_we}, 32'd0);
        chk("err_low_addr", mem_addr, 32'd0);
        tick();
        chk("err_low_ready", {31'b0, req_ready}, 32'd1);
        issue(1'b0, 1'b0, 32'h0001_FFFE, 32'h0);
        chk("err_high_valid", {31'b0, resp_valid}, 32'd1);
        chk("err_high_err", {31'b0, resp_err}, 32'd1);
        tick();
        issue(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);
        chk("err_wrap_valid", {31'b0, resp_valid}, 32'd1);
        chk("err_wrap_err", {31'b0, resp_err}, 32'd1);
        chk("err_wrap_we", {31'b0, mem_we}, 32'd0);
        tick();
        issue(1'b0, 1'b1, 32'h0001_FFFF, 32'h0);
        chk("lbu_top_addr", mem_addr, 32'h0001_FFFF);
        chk("lbu_top_no_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("lbu_top_valid", {31'b0, resp_valid}, 32'd1);
        chk("lbu_top_err", {31'b0, resp_err}, 32'd0);
        chk("lbu_top_rd", resp_rd, 32'h0000_005A);
        tick();

        // Reset during beat k=2 of a split store
        mem[8'h02] = 8'h00;
        mem[8'h03] = 8'h00;
        mem[8'h04] = 8'h00;
        mem[8'h05] = 8'h00;
        p0 = pulses;
        issue(1'b1, 1'b0, 32'h0001_0002, 32'hA1B2_C3D4);
        tick();
        tick();
        chk("rsw_k2_addr", mem_addr, 32'h0001_0004);
        rst = 1'b1;
        #1;
        chk("rsw_we_gated", {31'b0, mem_we}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rsw_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("rsw_ready", {31'b0, req_ready}, 32'd1);
        tick();
        tick();
        chk("rsw_no_pulse", 32'(pulses - p0), 32'd0);
        chk("rsw_mem_bytes", {mem[8'h05], mem[8'h04], mem[8'h03], mem[8'h02]}, 32'h0000_C3D4);

        // Back-to-back aligned stores with valid held high
        p0 = pulses;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h0001_0008;
        req_wd    = 32'h0102_0304;
        chk("b2b_ready_n", {31'b0, req_ready}, 32'd1);
        tick();
        req_addr  = 32'h0001_000C;
        req_wd    = 32'h0506_0708;
        chk("b2b_n1_ready", {31'b0, req_ready}, 32'd0);
        chk("b2b_n1_addr", mem_addr, 32'h0001_0008);
        chk("b2b_n1_wd", mem_wd, 32'h0102_0304);
        tick();
        chk("b2b_n2_ready", {31'b0, req_ready}, 32'd0);
        chk("b2b_n2_valid", {31'b0, resp_valid}, 32'd1);
        tick();
        chk("b2b_n3_ready", {31'b0, req_ready}, 32'd1);
        chk("b2b_n3_valid", {31'b0, resp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b_n4_addr", mem_addr, 32'h0001_000C);
        chk("b2b_n4_wd", mem_wd, 32'h0506_0708);
        tick();
        chk("b2b_n5_valid", {31'b0, resp_valid}, 32'd1);
        tick();
        tick();
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);
        chk("b2b_mem_w0", {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]}, 32'h0102_0304);
        chk("b2b_mem_w1", {mem[8'h0F], mem[8'h0E], mem[8'h0D], mem[8'h0C]}, 32'h0506_0708);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting between the CPU execute stage and `data_memory`. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's `addr/wd/we/byte_op` port. Aligned word and byte accesses complete as a single memory access; misaligned word accesses are split into four byte beats. The unit returns read data or a completion/error pulse to the pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data/address width
- `BYTE_WIDTH`, 8, byte width
- `START_ADDRESS`, 32'h10000, lowest legal data address
- `END_ADDRESS`, 32'h1FFFF, highest legal data address

Ports:
- `clk`  in  1  clock; memory writes land on its negedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  unit can accept a request
- `req_we_i`  in  1  1 = store, 0 = load
- `req_byte_i`  in  1  1 = byte op (SB/LBU), 0 = word (SW/LW)
- `req_addr_i`  in  32  byte address
- `req_wd_i`  in  32  store data
- `resp_valid_o`  out  1  one-cycle completion pulse, loads and stores
- `resp_rd_o`  out  32  load data, zero-extended for bytes
- `resp_err_o`  out  1  access out of range, valid with `resp_valid_o`
- `mem_addr_o`  out  32  memory address
- `mem_wd_o`  out  32  memory write data
- `mem_we_o`  out  1  memory write enable
- `mem_byte_op_o`  out  1  memory byte-op select
- `mem_rd_i`  in  32  memory read data, combinational from `mem_addr_o`

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - `req_ready_o=1`.
  - On `req_valid_i`, latch we/byte/addr/wd. Later changes on the request inputs are ignored.
- Range check on the latched request:
  - Legal when `addr >= START_ADDRESS` and `last <= END_ADDRESS`.
  - `last = addr` for byte ops, `addr+3` for word ops, computed in 33 bits. Carry out of 32 bits is illegal.
- Transitions out of IDLE:
  - Illegal → RESP with err=1, rd=0. No memory cycle is driven.
  - Legal byte op or aligned word (`addr[1:0]==0`) → ACCESS.
  - Legal misaligned word → SPLIT with beat counter k=0.
- ACCESS (1 cycle):
  - `mem_addr_o=addr`, `mem_byte_op_o=byte`, `mem_we_o=we`, `mem_wd_o=wd`.
  - Load captures `mem_rd_i` at the posedge ending the cycle. For byte loads, only `[7:0]` is kept and upper bits are zeroed.
  - → RESP.
- SPLIT (4 cycles, k=0..3):
  - `mem_addr_o=addr+k`, `mem_byte_op_o=1`, `mem_we_o=we`.
  - `mem_wd_o[7:0]=wd[8k+7:8k]`, upper bits 0.
  - Load: `rd[8k+7:8k] <= mem_rd_i[7:0]`.
  - k==3 → RESP.
- RESP (1 cycle):
  - `resp_valid_o=1`, with `resp_rd_o` and `resp_err_o` valid.
  - For stores, `resp_rd_o=0`.
  - There is no backpressure; the consumer must take the pulse. → IDLE.
- Outside ACCESS/SPLIT, all `mem_*` outputs are 0.
- Reset mid-operation:
  - Returns to IDLE and aborts the request. No response is issued.
  - Split-store beats already written stay in memory; this is a torn write, and the pipeline must reissue.
  - `mem_we_o` is gated by `!rst` so no write occurs in the reset cycle.

## Timing
- Reset values:
  - `req_ready_o=1`.
  - `resp_valid_o`, `resp_err_o`, `resp_rd_o` all 0.
  - All `mem_*` outputs 0.
  - State IDLE, k=0.
- Handshake at edge N (valid&&ready):
  - Aligned or byte access: memory cycle N+1, `resp_valid_o` during N+2.
  - Misaligned word: beats N+1..N+4, response N+5.
  - Out of range: response N+1.
- `req_ready_o` is low from N+1 until the response cycle ends.
- Next acceptance earliest at edge N+3 (aligned), N+6 (split), N+2 (error).
- Memory outputs are combinational decodes of registered state and latched fields, stable for the whole cycle before the negedge write.

## Structure
- `lsu_pkg`:
  - `lsu_state_t` enum.
  - `BYTE_WIDTH`, default `START_ADDRESS`/`END_ADDRESS` constants.
  - `LAST_BYTE_OFFSET=3`.
- Sub-module `lsu_range_check`: combinational, with inputs addr and byte and output legal. Isolates the 33-bit compare so it can be reused by a future instruction-fetch port.

## Test plan
- Aligned LW:
  - Memory bytes 11,22,33,44 at 0x10004..7; LW 0x10004.
  - → one cycle `mem_addr_o=0x10004`, `byte_op=0`.
  - → `resp_rd_o=0x44332211`, err=0 at N+2.
- Byte store then load:
  - SB 0x10001, wd=0xDEADBEEF → one cycle `mem_we_o=1`, `byte_op=1`, `mem_wd_o[7:0]=0xEF`.
  - Then LBU 0x10001 → `resp_rd_o=0x000000EF`.
- Misaligned word store then load:
  - SW 0x10002, wd=0xA1B2C3D4 → four beats at addrs 0x10002..5 with bytes D4,C3,B2,A1; resp at N+5.
  - Then LW 0x10002 → `resp_rd_o=0xA1B2C3D4` at N+5.
- Range errors:
  - LW 0x0FFFC → resp at N+1, err=1, rd=0, `mem_we_o` never 1.
  - LW 0x1FFFE → err=1 (last=0x20001).
  - LW 0xFFFFFFFE → err=1 (carry out).
  - LBU 0x1FFFF → legal.
- Reset during split store:
  - Assert rst during beat k=2 of SW 0x10002, wd=0xA1B2C3D4.
  - → bytes D4,C3 written at 0x10002/3; 0x10004/5 unchanged; no `resp_valid_o`.
  - → `req_ready_o=1` the cycle after reset deasserts.
- Back-to-back requests:
  - `req_valid_i` held high with two aligned SW.
  - → `req_ready_o` low for 2 cycles; second accepted at N+3; exactly two `resp_valid_o` pulses at N+2 and N+5.
